// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / data) in front of a single-port memory, one outstanding access.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mem_arbiter #(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [nbits-1:0] i_addr,
  input  logic             i_flush,
  output logic             i_rdy,
  output logic             i_valid,
  output logic [nbits-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [nbits-1:0] d_addr,
  input  logic [nbits-1:0] d_wdata,
  output logic             d_rdy,
  output logic             d_valid,
  output logic [nbits-1:0] d_rdata,
  output logic             mem_req,
  input  logic             mem_rdy,
  output logic [nbits-1:0] mem_addr,
  output logic             mem_we,
  output logic [nbits-1:0] mem_wdata,
  input  logic             mem_valid,
  input  logic [nbits-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D} state_t;

  state_t r_state;
  state_t w_next;
  logic   r_kill;
  logic   w_kill_next;
  logic   w_pref_d;
  logic   w_mreq;
  logic   w_own_d;
  logic   w_hs;
  logic   w_ivalid;
  logic   w_dvalid;
  logic   w_on;

`ifdef MEM_ARB_RR_EN
  logic r_last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (w_hs) begin
      r_last_d <= w_own_d;
    end
  end

  // On a tie the port that did not win last time is favoured.
  assign w_pref_d = ~r_last_d;
`else
  assign w_pref_d = 1'b1;
`endif

  assign w_hs = w_mreq & mem_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_kill  <= w_kill_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_kill_next = 1'b0;
    w_mreq      = 1'b0;
    w_own_d     = 1'b0;
    w_ivalid    = 1'b0;
    w_dvalid    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req | d_req) begin
          w_mreq  = 1'b1;
          w_own_d = d_req & (~i_req | w_pref_d);
          if (mem_rdy) begin
            w_next = w_own_d ? WAIT_D : WAIT_I;
          end else begin
            w_next = w_own_d ? ISSUE_D : ISSUE_I;
          end
        end
      end
      ISSUE_I: begin
        if (i_flush) begin
          w_next = IDLE;
        end else begin
          w_mreq = 1'b1;
          if (mem_rdy) begin
            w_next = WAIT_I;
          end
        end
      end
      ISSUE_D: begin
        w_mreq  = 1'b1;
        w_own_d = 1'b1;
        if (mem_rdy) begin
          w_next = WAIT_D;
        end
      end
      WAIT_I: begin
        // A flush in the response cycle itself also drops the response.
        w_kill_next = ~mem_valid & (r_kill | i_flush);
        if (mem_valid) begin
          w_ivalid = ~(r_kill | i_flush);
          w_next   = IDLE;
        end
      end
      WAIT_D: begin
        w_own_d = 1'b1;
        if (mem_valid) begin
          w_dvalid = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, independent of the registered state.
  assign w_on      = ~rst;
  assign mem_req   = w_on & w_mreq;
  assign mem_addr  = mem_req ? (w_own_d ? d_addr : i_addr) : '0;
  assign mem_we    = mem_req & w_own_d & d_we;
  assign mem_wdata = mem_we ? d_wdata : '0;
  assign i_rdy     = mem_req & mem_rdy & ~w_own_d;
  assign d_rdy     = mem_req & mem_rdy & w_own_d;
  assign i_valid   = w_on & w_ivalid;
  assign d_valid   = w_on & w_dvalid;
  assign i_rdata   = i_valid ? mem_rdata : '0;
  assign d_rdata   = d_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
  localparam int NB = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_flush, i_rdy, i_valid;
  logic [NB-1:0] i_addr, i_rdata;
  logic          d_req, d_we, d_rdy, d_valid;
  logic [NB-1:0] d_addr, d_wdata, d_rdata;
  logic          mem_req, mem_rdy, mem_we, mem_valid;
  logic [NB-1:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.nbits(NB)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_rdy(i_rdy),
    .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_rdy(mem_rdy), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  // Memory environment (reacts to the DUT's memory port) and reference store (requester view).
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  typedef struct {
    bit          port_d;
    logic [31:0] data;
    bit          killed;
  } txn_t;
  txn_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model (negedge) ----------------
  bit          m_busy = 0, m_owner_d = 0, m_last_d = 0;
  int          m_lock = 0;  // 0 free, 1 fetch holds grant, 2 data holds grant
  bit          resp_due = 0, exp_rst = 1, exp_mreq = 0, chk_wdata = 0;
  logic [3:0]  exp_ctl = '0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  bit          own_d, mreq, hs, pref_d;
  logic [31:0] tdata, taddr;

  always @(negedge clk) begin
    resp_due = 0;
    exp_rst  = rst;
    if (rst) begin
      m_busy = 0; m_lock = 0; m_last_d = 0;
      exp_q.delete();
    end else begin
      own_d = 0; mreq = 0;
`ifdef MEM_ARB_RR_EN
      pref_d = !m_last_d;
`else
      pref_d = 1;
`endif
      if (m_busy) begin
        if (!m_owner_d && i_flush && exp_q.size() != 0) exp_q[0].killed = 1;
        if (mem_valid) begin resp_due = 1; m_busy = 0; end
      end else if (m_lock == 1) begin
        if (i_flush) m_lock = 0;
        else mreq = 1;
      end else if (m_lock == 2) begin
        mreq = 1; own_d = 1;
      end else if (i_req || d_req) begin
        mreq = 1; own_d = d_req && (!i_req || pref_d);
      end
      hs        = mreq && mem_rdy;
      exp_mreq  = mreq;
      exp_ctl   = {mreq, hs && !own_d, hs && own_d, mreq && own_d && d_we};
      exp_addr  = own_d ? d_addr : i_addr;
      exp_wdata = (own_d && d_we) ? d_wdata : 32'h0;
      chk_wdata = mreq && (!own_d || d_we);
      if (hs) begin
        m_busy = 1; m_owner_d = own_d; m_lock = 0; m_last_d = own_d;
        taddr = own_d ? d_addr : i_addr;
        if (own_d && d_we) begin
          ref_mem[taddr] = d_wdata;
          tdata = d_wdata;
        end else begin
          tdata = ref_mem.exists(taddr) ? ref_mem[taddr] : init_val(taddr);
        end
        exp_q.push_back('{own_d, tdata, 1'b0});
      end else if (mreq) begin
        m_lock = own_d ? 2 : 1;
      end
    end
  end

  // ---------------- monitor / checker ----------------
  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  bit   to_flag = 0, to_reported = 0;
  txn_t t;

  always begin
    @(negedge clk);
    #1;
    if (to_flag && !to_reported) begin
      to_reported = 1;
      check("wait_timeout", 1, 0);
    end
    if (exp_rst) begin
      check("reset_outs", {i_rdy, i_valid, i_rdata, d_rdy, d_valid, d_rdata,
                           mem_req, mem_addr, mem_we, mem_wdata}, '0);
    end else begin
      check("ctl{req,irdy,drdy,we}", {mem_req, i_rdy, d_rdy, mem_we}, exp_ctl);
      if (exp_mreq) check("mem_addr", mem_addr, exp_addr);
      if (chk_wdata) check("mem_wdata", mem_wdata, exp_wdata);
      if (resp_due && exp_q.size() != 0) begin
        t = exp_q.pop_front();
        check("resp_valid{i,d}", {i_valid, d_valid}, {!t.port_d && !t.killed, t.port_d});
        if (t.port_d) check("d_rdata", d_rdata, t.data);
        else if (!t.killed) check("i_rdata", i_rdata, t.data);
      end else begin
        check("no_stray_valid", {i_valid, d_valid}, 2'b00);
      end
      check("rdata_gating", {i_valid ? 32'h0 : i_rdata, d_valid ? 32'h0 : d_rdata}, '0);
    end
  end

  // ---------------- stimulus: requesters and memory environment ----------------
  bit          i_pend = 0, d_pend = 0, hold = 0;
  int          cnt = 0;
  logic [31:0] resp_data = '0;

  task automatic cycle_step();
    @(negedge clk);
    if (!rst) begin
      if (mem_req && mem_rdy) begin
        if (mem_we) env_mem[mem_addr] = mem_wdata;
        resp_data = env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_val(mem_addr);
        cnt = int'($urandom_range(1, 3));
      end
      if (i_rdy) i_pend = 0;
      if (d_rdy) d_pend = 0;
    end
    @(posedge clk);
    #1;
    if (cnt != 0) begin
      cnt--;
      mem_valid = (cnt == 0);
    end else begin
      mem_valid = 1'b0;
    end
    mem_rdata = mem_valid ? resp_data : $urandom();
    mem_rdy   = ($urandom_range(0, 3) != 0);
    i_flush   = ($urandom_range(0, 6) == 0);
    if (!i_pend && !hold && $urandom_range(0, 2) == 0) begin
      i_pend = 1;
      i_addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
    end
    if (!d_pend && !hold && $urandom_range(0, 2) == 0) begin
      d_pend  = 1;
      d_addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      d_we    = ($urandom_range(0, 2) == 0);
      d_wdata = $urandom();
    end
    i_req = i_pend;
    d_req = d_pend;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    i_pend = 1; d_pend = 1;
    i_req = 1'b1; i_addr = 32'h10; i_flush = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    mem_rdy = 1'b1; mem_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int ph = 0; ph < 3; ph++) begin
      repeat (1500) cycle_step();
      guard = 0;
      while (!(m_busy && m_owner_d) && guard < 2000) begin
        cycle_step();
        guard++;
      end
      if (guard >= 2000) to_flag = 1;
      // Abandon the outstanding data access; its response is made to arrive after reset.
      rst = 1'b1; hold = 1;
      i_pend = 0; d_pend = 0; i_req = 1'b0; d_req = 1'b0;
      mem_valid = 1'b0; cnt = 4;
      repeat (2) cycle_step();
      rst = 1'b0;
      repeat (6) cycle_step();
      hold = 0;
    end
    repeat (5) cycle_step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
